// File: rtl/clk_rst_pkg.sv
// ----------------------------------------------------------------------------
// clk_rst_pkg
//   Shared types and default timing for the reset sequencer that sits between
//   the clock-generator wrapper and the SoC top.
//
//   Contents:
//     state_t         sequencer states
//     DEF_*           default timing constants (cycles of clk_sys)
//     max_int()       elaboration-time helper used to size the shared counter
// ----------------------------------------------------------------------------
package clk_rst_pkg;

    typedef enum logic [2:0] {
        S_MRST,       // holding the MMCM in reset
        S_WAIT_LOCK,  // waiting for the MMCM to report lock
        S_STABLE,     // lock seen, waiting for it to stay up long enough
        S_RELEASE,    // releasing downstream domains one at a time
        S_RUN         // every domain out of reset
    } state_t;

    localparam int DEF_N_DOMAINS       = 4;
    localparam int DEF_MMCM_RST_CYCLES = 8;
    localparam int DEF_STABLE_CYCLES   = 1024;
    localparam int DEF_STAGE_GAP       = 16;
    localparam int DEF_LOCK_TIMEOUT    = 65536;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// ----------------------------------------------------------------------------
// sync_2ff
//   Generic two-flop synchronizer for a single asynchronous level signal.
//
//   Parameters:
//     RST_VAL  value both flops take while rst is high
//
//   Ports:
//     clk  in   destination-domain clock
//     rst  in   synchronous, active-high reset
//     d    in   asynchronous input
//     q    out  synchronized output, lags d by two clk edges
// ----------------------------------------------------------------------------
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: sequential state is always written with non-blocking assignments so
    // every flop samples the pre-edge value of its source; a blocking '=' here
    // would collapse the two stages into one.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/clk_rst_seq.sv
// ----------------------------------------------------------------------------
// clk_rst_seq
//   Watches MMCM lock, pulses the MMCM reset when lock never arrives, and
//   releases N_DOMAINS downstream resets in ascending order once lock has been
//   stable. Runs on the free-running reference clock so it keeps working while
//   the MMCM output is absent.
//
//   Ports:
//     clk_sys          in   free-running reference clock
//     rst_sys          in   synchronous, active-high reset
//     locked_i         in   MMCM locked, asynchronous to clk_sys
//     sw_rst_req_i     in   software/debug reset request (level, clk_sys sync)
//     mmcm_rst_o       out  MMCM reset, active-high
//     rst_n_o          out  per-domain reset, active-low, domain 0 first
//     rst_done_o       out  high when all domains are released
//     lock_loss_cnt_o  out  saturating count of lock losses + lock timeouts
// ----------------------------------------------------------------------------
module clk_rst_seq
    import clk_rst_pkg::*;
#(
    parameter int N_DOMAINS       = DEF_N_DOMAINS,
    parameter int MMCM_RST_CYCLES = DEF_MMCM_RST_CYCLES,
    parameter int STABLE_CYCLES   = DEF_STABLE_CYCLES,
    parameter int STAGE_GAP       = DEF_STAGE_GAP,
    parameter int LOCK_TIMEOUT    = DEF_LOCK_TIMEOUT
) (
    input  logic                 clk_sys,
    input  logic                 rst_sys,
    input  logic                 locked_i,
    input  logic                 sw_rst_req_i,
    output logic                 mmcm_rst_o,
    output logic [N_DOMAINS-1:0] rst_n_o,
    output logic                 rst_done_o,
    output logic [7:0]           lock_loss_cnt_o
);

    localparam int CNT_W = $clog2(max_int(LOCK_TIMEOUT, STABLE_CYCLES)) + 1;

    localparam logic [CNT_W-1:0]     MRST_LAST    = CNT_W'(MMCM_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]     TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]     STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]     GAP_LAST     = CNT_W'(STAGE_GAP - 1);
    localparam logic [N_DOMAINS-1:0] DOMAIN0      = N_DOMAINS'(1);
    localparam logic [7:0]           LOSS_MAX     = 8'hFF;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [N_DOMAINS-1:0] rst_n_d;
    logic                 mmcm_rst_d;
    logic                 rst_done_d;
    logic [7:0]           loss_cnt_d;
    logic                 loss_inc;
    logic                 lock_s;

    sync_2ff #(
        .RST_VAL (1'b0)
    ) u_lock_sync (
        .clk (clk_sys),
        .rst (rst_sys),
        .d   (locked_i),
        .q   (lock_s)
    );

    // NOTE: every signal written here gets a default before the case statement,
    // so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rst_n_d  = rst_n_o;
        loss_inc = 1'b0;

        case (state_q)
            S_MRST: begin
                if (cnt_q == MRST_LAST) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = S_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d  = S_MRST;
                    cnt_d    = '0;
                    loss_inc = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_STABLE: begin
                // Domains are still held here, so losing lock is not counted.
                if (!lock_s) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (sw_rst_req_i) begin
                    cnt_d = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    cnt_d   = '0;
                    rst_n_d = DOMAIN0;
                    // A single-domain build is fully released on entry.
                    state_d = rst_n_d[N_DOMAINS-1] ? S_RUN : S_RELEASE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_RELEASE, S_RUN: begin
                // Lock loss is checked first so it wins over a coincident
                // software request.
                if (!lock_s) begin
                    state_d  = S_WAIT_LOCK;
                    cnt_d    = '0;
                    rst_n_d  = '0;
                    loss_inc = 1'b1;
                end else if (sw_rst_req_i) begin
                    state_d = S_STABLE;
                    cnt_d   = '0;
                    rst_n_d = '0;
                end else if (state_q == S_RELEASE) begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_d = '0;
                        // Shifting a one in from the bottom releases the next
                        // domain up and never re-asserts a released one.
                        rst_n_d = (rst_n_o << 1) | DOMAIN0;
                        if (rst_n_d[N_DOMAINS-1]) begin
                            state_d = S_RUN;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            default: begin
                state_d = S_MRST;
                cnt_d   = '0;
                rst_n_d = '0;
            end
        endcase

        mmcm_rst_d = (state_d == S_MRST);
        rst_done_d = (state_d == S_RUN) && (&rst_n_d);
        loss_cnt_d = (loss_inc && (lock_loss_cnt_o != LOSS_MAX))
                   ? lock_loss_cnt_o + 8'd1
                   : lock_loss_cnt_o;
    end

    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            state_q         <= S_MRST;
            cnt_q           <= '0;
            mmcm_rst_o      <= 1'b1;
            rst_n_o         <= '0;
            rst_done_o      <= 1'b0;
            lock_loss_cnt_o <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            mmcm_rst_o      <= mmcm_rst_d;
            rst_n_o         <= rst_n_d;
            rst_done_o      <= rst_done_d;
            lock_loss_cnt_o <= loss_cnt_d;
        end
    end

endmodule

// File: tb/tb_clk_rst_seq.sv
// ----------------------------------------------------------------------------
// tb_clk_rst_seq
//   Self-checking bench for clk_rst_seq with small timing parameters.
//   Each table row holds inputs, a repeat count and the outputs expected after
//   every clock edge that samples those inputs. Inputs change on the falling
//   edge; the expectation is queued at the same time and popped one time unit
//   after the following rising edge.
// ----------------------------------------------------------------------------
module tb_clk_rst_seq;

    localparam int N_DOM    = 4;
    localparam int MRST_CYC = 4;
    localparam int TIMEOUT  = 32;

    logic             clk_sys = 1'b0;
    logic             rst_sys;
    logic             locked_i;
    logic             sw_rst_req_i;
    logic             mmcm_rst_o;
    logic [N_DOM-1:0] rst_n_o;
    logic             rst_done_o;
    logic [7:0]       lock_loss_cnt_o;

    clk_rst_seq #(
        .N_DOMAINS       (N_DOM),
        .MMCM_RST_CYCLES (MRST_CYC),
        .STABLE_CYCLES   (8),
        .STAGE_GAP       (2),
        .LOCK_TIMEOUT    (TIMEOUT)
    ) dut (
        .clk_sys         (clk_sys),
        .rst_sys         (rst_sys),
        .locked_i        (locked_i),
        .sw_rst_req_i    (sw_rst_req_i),
        .mmcm_rst_o      (mmcm_rst_o),
        .rst_n_o         (rst_n_o),
        .rst_done_o      (rst_done_o),
        .lock_loss_cnt_o (lock_loss_cnt_o)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        string            tag;
        int               reps;
        bit               chk;
        logic             rst;
        logic             lk;
        logic             sw;
        logic             mmcm;
        logic [N_DOM-1:0] rst_n;
        logic             done;
        logic [7:0]       cnt;
    } vec_t;

    typedef struct {
        string            tag;
        logic             mmcm;
        logic [N_DOM-1:0] rst_n;
        logic             done;
        logic [7:0]       cnt;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input string tag, input int reps, input logic rst, input logic lk,
                       input logic sw, input logic mmcm, input logic [N_DOM-1:0] rn,
                       input logic done, input logic [7:0] cnt);
        vec_t v;
        v.tag = tag;  v.reps = reps; v.chk = 1'b1;
        v.rst = rst;  v.lk = lk;     v.sw = sw;
        v.mmcm = mmcm; v.rst_n = rn; v.done = done; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    // Staged release with STAGE_GAP = 2, locked and no software request.
    task automatic add_release(input string tag, input logic [7:0] cnt);
        add({tag, "_r1"}, 2, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b0, cnt);
        add({tag, "_r2"}, 2, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0011, 1'b0, cnt);
        add({tag, "_r3"}, 2, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0111, 1'b0, cnt);
        add({tag, "_run"}, 3, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1111, 1'b1, cnt);
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        for (int r = 0; r < v.reps; r++) begin
            @(negedge clk_sys);
            rst_sys      = v.rst;
            locked_i     = v.lk;
            sw_rst_req_i = v.sw;
            if (v.chk) begin
                e.tag   = $sformatf("%s[%0d]", v.tag, r);
                e.mmcm  = v.mmcm;
                e.rst_n = v.rst_n;
                e.done  = v.done;
                e.cnt   = v.cnt;
                sb_q.push_back(e);
            end
        end
    endtask

    // Scoreboard side: compare the outputs produced by the edge that sampled
    // the queued stimulus.
    always @(posedge clk_sys) begin
        #1;
        if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            check({mon_e.tag, ".mmcm_rst"}, 32'(mmcm_rst_o), 32'(mon_e.mmcm));
            check({mon_e.tag, ".rst_n"}, 32'(rst_n_o), 32'(mon_e.rst_n));
            check({mon_e.tag, ".rst_done"}, 32'(rst_done_o), 32'(mon_e.done));
            check({mon_e.tag, ".loss_cnt"}, 32'(lock_loss_cnt_o), 32'(mon_e.cnt));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t sat;

        rst_sys      = 1'b1;
        locked_i     = 1'b0;
        sw_rst_req_i = 1'b0;

        // Power-up: 4-cycle MMCM pulse, lock 10 cycles after it falls,
        // 2 sync cycles + 8 stable cycles, then 2-cycle release stages.
        add("pwr_rst",   2, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 8'd0);
        add("pwr_mrst",  3, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 8'd0);
        add("pwr_wait", 10, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 8'd0);
        add("pwr_stab", 10, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 8'd0);
        add_release("pwr", 8'd0);

        // Lock drop in RUN: resets assert 3 edges after the locked_i fall,
        // re-lock reruns the release with no MMCM pulse.
        add("drop_sync", 2, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b1, 8'd0);
        add("drop_hit",  1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 8'd1);
        add("drop_wait", 3, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 8'd1);
        add("drop_stab",10, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 8'd1);
        add_release("drop", 8'd1);

        // Software request held 5 cycles in RUN: count unchanged, release
        // restarts after 8 locked cycles with the request low.
        add("sw_hold",   5, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 8'd1);
        add("sw_stab",   7, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 8'd1);
        add_release("sw", 8'd1);

        // Lock glitch seen while the stable counter is at 5: no release, the
        // stable count restarts from zero after re-lock.
        add("gl_enter",  1, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 8'd1);
        add("gl_count",  3, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 8'd1);
        add("gl_low",    3, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 8'd1);
        add("gl_stab",  10, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 8'd1);
        add_release("gl", 8'd1);

        // Software request on the same edge that sees lock fall: lock loss wins.
        add("both_sync", 2, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b1, 8'd1);
        add("both_hit",  1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 8'd2);
        add("both_wait", 2, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 8'd2);
        add("both_stab",10, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 8'd2);
        add_release("both", 8'd2);

        // Reset mid-release with 0011 released.
        add("mr_sw",     1, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 8'd2);
        add("mr_stab",   7, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 8'd2);
        add("mr_r1",     2, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b0, 8'd2);
        add("mr_r2",     1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0011, 1'b0, 8'd2);
        add("mr_rst",    1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 8'd0);

        // No lock after reset: MMCM re-pulses every 4 + 32 cycles, count steps.
        add("to_mrst0",  3, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 8'd0);
        add("to_wait0", 32, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 8'd0);
        add("to_mrst1",  4, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 8'd1);
        add("to_wait1", 32, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 8'd1);
        add("to_mrst2",  4, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 8'd2);
        add("to_wait2", 32, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 8'd2);
        add("to_mrst3",  4, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 8'd3);

        foreach (vecs[i]) apply(vecs[i]);

        // Saturation: 300 further timeouts must leave the count pinned at 255.
        sat = vecs[vecs.size() - 1];
        sat.tag  = "sat";
        sat.reps = 300 * (MRST_CYC + TIMEOUT);
        sat.chk  = 1'b0;
        apply(sat);
        @(posedge clk_sys);
        #2;
        check("sat.loss_cnt", 32'(lock_loss_cnt_o), 32'd255);

        // Reset from the saturated count clears it.
        vecs.delete();
        add("sat_rst", 1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 8'd0);
        apply(vecs[0]);

        for (int k = 0; k < 4 && sb_q.size() != 0; k++) begin
            @(posedge clk_sys);
            #3;
        end
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
